// File: rtl/calc_sequencer.sv
// Purpose : control sequencer for a 4-digit BCD calculator: digit entry, operand
//           capture, ALU handshake with timeout, result/error display.
// Latency : all outputs registered or decoded from registered state; alu_start one
//           cycle after arith_pulse; ERROR ALU_TIMEOUT cycles after BUSY entry.
// Backpressure: none; pulses are consumed in the cycle they arrive or dropped.
// Ports   : clk/rst (sync, active-low); clr_pulse, ent_pulse, digit_inc[3:0],
//           arith_pulse, op_sel from the keypad; alu_a/alu_b/alu_op/alu_start to the
//           ALU, alu_done/alu_result/alu_neg/alu_ovf back; display_value/display_neg,
//           error and state to the front panel.
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_pulse,
  input  logic        ent_pulse,
  input  logic [3:0]  digit_inc,
  input  logic        arith_pulse,
  input  logic        op_sel,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_neg,
  input  logic        alu_ovf,
  output logic [15:0] display_value,
  output logic        display_neg,
  output logic        error,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    ENTRY_B = 3'd1,
    OP_WAIT = 3'd2,
    BUSY    = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int CW = $clog2(ALU_TIMEOUT) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(ALU_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   entry_q, entry_d;
  logic [15:0]   opa_q, opa_d;
  logic [15:0]   opb_q, opb_d;
  logic [15:0]   result_q, result_d;
  logic          neg_q, neg_d;
  logic          op_q, op_d;
  logic          start_q, start_d;
  logic [CW-1:0] tmo_q, tmo_d;

  // Each set bit bumps its own BCD nibble, 9 wrapping to 0.
  function automatic logic [15:0] inc_digits(input logic [15:0] v, input logic [3:0] inc);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < 4; k++) begin
      if (inc[k]) begin
        r[4*k +: 4] = (v[4*k +: 4] >= 4'd9) ? 4'd0 : v[4*k +: 4] + 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    neg_d    = neg_q;
    op_d     = op_q;
    start_d  = 1'b0;
    tmo_d    = '0;

    if (clr_pulse) begin
      state_d  = ENTRY_A;
      entry_d  = '0;
      opa_d    = '0;
      opb_d    = '0;
      result_d = '0;
      neg_d    = 1'b0;
      op_d     = 1'b0;
    end else begin
      case (state_q)
        ENTRY_A: begin
          if (ent_pulse) begin
            opa_d   = entry_q;
            entry_d = '0;
            state_d = ENTRY_B;
          end else begin
            entry_d = inc_digits(entry_q, digit_inc);
          end
        end
        ENTRY_B: begin
          if (ent_pulse) begin
            opb_d   = entry_q;
            entry_d = '0;
            state_d = OP_WAIT;
          end else begin
            entry_d = inc_digits(entry_q, digit_inc);
          end
        end
        OP_WAIT: begin
          if (arith_pulse) begin
            op_d    = op_sel;
            start_d = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          // alu_done beats the timeout when both land on the last count.
          if (alu_done) begin
            if (alu_ovf) begin
              state_d = ERROR;
            end else begin
              result_d = alu_result;
              neg_d    = alu_neg;
              state_d  = RESULT;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = ERROR;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
        RESULT: begin
          if (ent_pulse) begin
            opa_d   = result_q;
            neg_d   = 1'b0;
            entry_d = '0;
            state_d = ENTRY_B;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = ENTRY_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ENTRY_A;
      entry_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      op_q     <= 1'b0;
      start_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      start_q  <= start_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    display_value = '0;
    case (state_q)
      ENTRY_A, ENTRY_B: display_value = entry_q;
      OP_WAIT, BUSY:    display_value = opb_q;
      RESULT:           display_value = result_q;
      default:          display_value = '0;
    endcase
  end

  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_op      = op_q;
  assign alu_start   = start_q;
  assign display_neg = (state_q == RESULT) && neg_q;
  assign error       = (state_q == ERROR);
  assign state       = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Purpose : self-checking bench for calc_sequencer: directed scenarios followed by
//           randomized keypad/ALU traffic, scored against a decimal reference model.
// Latency : expected outputs are queued at each drive edge and checked after the next clock.
// Backpressure: none.
module tb_calc_sequencer;

  localparam int TMO = 8;
  localparam int S_A = 0, S_B = 1, S_W = 2, S_BUSY = 3, S_RES = 4, S_ERR = 5;

  logic        clk;
  logic        rst;
  logic        clr_pulse, ent_pulse, arith_pulse, op_sel;
  logic [3:0]  digit_inc;
  logic [15:0] alu_a, alu_b, alu_result, display_value;
  logic        alu_op, alu_start, alu_done, alu_neg, alu_ovf, display_neg, error;
  logic [2:0]  state;

  calc_sequencer #(.ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .clr_pulse(clr_pulse), .ent_pulse(ent_pulse),
    .digit_inc(digit_inc), .arith_pulse(arith_pulse), .op_sel(op_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
    .display_value(display_value), .display_neg(display_neg), .error(error), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        clr;
    logic        ent;
    logic [3:0]  inc;
    logic        arith;
    logic        op;
    logic        done;
    logic [15:0] res;
    logic        neg;
    logic        ovf;
  } stim_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        start;
    logic [15:0] disp;
    logic        dneg;
    logic        err;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: operands held as plain decimal integers.
  int m_st = S_A, m_entry = 0, m_opa = 0, m_opb = 0, m_res = 0, m_busy = 0;
  bit m_neg = 0, m_op = 0, m_start = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function void model_step(input stim_t s);
    int p, d;
    m_start = 0;
    if (!s.rst_n || s.clr) begin
      m_st = S_A; m_entry = 0; m_opa = 0; m_opb = 0; m_res = 0;
      m_neg = 0; m_op = 0; m_busy = 0;
    end else begin
      case (m_st)
        S_A, S_B: begin
          if (s.ent) begin
            if (m_st == S_A) m_opa = m_entry; else m_opb = m_entry;
            m_entry = 0;
            m_st = (m_st == S_A) ? S_B : S_W;
          end else begin
            p = 1;
            for (int k = 0; k < 4; k++) begin
              d = (m_entry / p) % 10;
              if (s.inc[k]) m_entry = m_entry - d * p + ((d + 1) % 10) * p;
              p = p * 10;
            end
          end
        end
        S_W: if (s.arith) begin
          m_op = s.op; m_st = S_BUSY; m_start = 1; m_busy = 0;
        end
        S_BUSY: begin
          m_busy++;
          if (s.done) begin
            if (s.ovf) m_st = S_ERR;
            else begin
              m_res = from_bcd(s.res); m_neg = s.neg; m_st = S_RES;
            end
          end else if (m_busy >= TMO) m_st = S_ERR;
        end
        S_RES: if (s.ent) begin
          m_opa = m_res; m_neg = 0; m_entry = 0; m_st = S_B;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t e;
    e.st    = 3'(m_st);
    e.a     = to_bcd(m_opa);
    e.b     = to_bcd(m_opb);
    e.op    = m_op;
    e.start = m_start;
    e.disp  = (m_st == S_A || m_st == S_B) ? to_bcd(m_entry) :
              (m_st == S_W || m_st == S_BUSY) ? to_bcd(m_opb) :
              (m_st == S_RES) ? to_bcd(m_res) : 16'h0000;
    e.dneg  = (m_st == S_RES) && m_neg;
    e.err   = (m_st == S_ERR);
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Behavioural ALU answering from the model's operands.
  function automatic stim_t with_resp(input stim_t s0);
    stim_t s;
    int r;
    s = s0;
    r = m_op ? (m_opa - m_opb) : (m_opa + m_opb);
    s.done = 1'b1;
    s.ovf  = (r > 9999);
    s.neg  = (r < 0);
    s.res  = (r > 9999) ? 16'($urandom) : to_bcd((r < 0) ? -r : r);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.rst_n; clr_pulse = s.clr; ent_pulse = s.ent; digit_inc = s.inc;
    arith_pulse = s.arith; op_sel = s.op; alu_done = s.done;
    alu_result = s.res; alu_neg = s.neg; alu_ovf = s.ovf;
    model_step(s);
    exp_q.push_back(model_snap());
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) drive(idle());
  endtask

  // Several digit bits pulse together while their digits still need counting.
  task automatic enter_num(input int v);
    stim_t s;
    for (int i = 0; i < 9; i++) begin
      s = idle();
      for (int k = 0; k < 4; k++) begin
        if (((v / (10 ** k)) % 10) > i) s.inc[k] = 1'b1;
      end
      if (s.inc != 4'b0000) drive(s);
    end
  endtask

  task automatic press(input bit clr, input bit ent, input bit arith, input bit op);
    stim_t s;
    s = idle();
    s.clr = clr; s.ent = ent; s.arith = arith; s.op = op;
    drive(s);
  endtask

  task automatic go_busy(input int a, input int b, input bit op);
    enter_num(a); press(0, 1, 0, 0);
    enter_num(b); press(0, 1, 0, 0);
    press(0, 0, 1, op);
  endtask

  task automatic rand_cycle();
    stim_t s;
    s = idle();
    if ($urandom_range(199) == 0) s.rst_n = 1'b0;
    if ($urandom_range(59) == 0) s.clr = 1'b1;
    if ($urandom_range(1) == 0) s.inc = 4'($urandom_range(15));
    s.op = 1'($urandom);
    s.ent = ($urandom_range(9) == 0);
    s.arith = ($urandom_range(9) == 0);
    case (m_st)
      S_A, S_B: s.ent = ($urandom_range(7) == 0);
      S_W:      s.arith = ($urandom_range(3) == 0);
      S_BUSY:   if ($urandom_range(4) == 0) s = with_resp(s);
      S_RES:    s.ent = ($urandom_range(3) == 0);
      S_ERR:    if ($urandom_range(3) == 0) s.clr = 1'b1;
      default: ;
    endcase
    if (m_st != S_BUSY && $urandom_range(9) == 0) begin
      s.done = 1'b1; s.res = 16'($urandom); s.neg = 1'($urandom); s.ovf = 1'($urandom);
    end
    drive(s);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set, compare it to the queue head.
  snap_t got, expv;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        got  = '{state, alu_a, alu_b, alu_op, alu_start, display_value, display_neg, error};
        checks++;
        if (got !== expv) begin
          errors++;
          $display("FAIL outputs t=%0t: got st=%0d a=%h b=%h op=%b start=%b disp=%h neg=%b err=%b, expected st=%0d a=%h b=%h op=%b start=%b disp=%h neg=%b err=%b",
                   $time, got.st, got.a, got.b, got.op, got.start, got.disp, got.dneg, got.err,
                   expv.st, expv.a, expv.b, expv.op, expv.start, expv.disp, expv.dneg, expv.err);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0; clr_pulse = 1'b0; ent_pulse = 1'b0; digit_inc = 4'b0000;
    arith_pulse = 1'b0; op_sel = 1'b0; alu_done = 1'b0; alu_result = '0;
    alu_neg = 1'b0; alu_ovf = 1'b0;

    s = idle(); s.rst_n = 1'b0;
    drive(s); drive(s);
    idles(1);

    // Digit wrap, then all four digits at once.
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.inc = 4'b0001; drive(s);
    end
    s = idle(); s.inc = 4'b1111; drive(s);
    press(1, 0, 0, 0);

    // Add path 12 + 34.
    go_busy(12, 34, 0);
    idles(2);
    s = idle(); s.done = 1'b1; s.res = 16'h0046; drive(s);
    idles(1);
    press(1, 0, 0, 0);

    // Subtract with negative result, then chain.
    go_busy(5, 9, 1);
    s = with_resp(idle()); drive(s);
    idles(1);
    press(0, 1, 0, 0);
    idles(1);
    press(1, 0, 0, 0);

    // Timeout, then clear out of ERROR.
    go_busy(1, 2, 0);
    idles(TMO + 3);
    press(1, 0, 0, 0);

    // Clear in the alu_start cycle; a late alu_done is ignored.
    go_busy(7, 8, 0);
    press(1, 0, 0, 0);
    idles(2);
    s = idle(); s.done = 1'b1; s.res = 16'h0015; drive(s);
    enter_num(3); press(0, 1, 0, 0);
    enter_num(4); press(1, 1, 0, 0);
    idles(1);

    // ent and arith together resolved by state.
    enter_num(21); press(0, 1, 1, 0);
    enter_num(43); press(0, 1, 1, 1);
    press(0, 1, 1, 1);
    s = with_resp(idle()); drive(s);
    press(0, 1, 1, 0);
    press(1, 0, 0, 0);

    // Reset mid-BUSY; alu_done afterwards is ignored.
    go_busy(9999, 1, 0);
    idles(2);
    s = idle(); s.rst_n = 1'b0; drive(s);
    idles(1);
    s = idle(); s.done = 1'b1; s.res = 16'h1234; drive(s);
    idles(1);

    for (int i = 0; i < 3000; i++) rand_cycle();
    idles(2);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
